// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one external full-adder cell, LSB first.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum_nx;
  // returned sum bit enters at the MSB so the LSB-first result lands in place
  assign sum_nx = {fa_sum, sum_r};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum_r <= sum_nx[WIDTH:1];
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign fa_a      = state == RUN && a_sh[0];
  assign fa_b      = state == RUN && b_sh[0];
  assign fa_cin    = state == RUN && carry;
  assign sum       = sum_r;
  assign cout      = carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: vector table plus corner sequences, results checked via a scoreboard queue.
module tb_serial_add_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, fa_a, fa_b, fa_cin, fa_sum, fa_cout, out_valid, cout, busy;
  logic [7:0] sum;
  int         checks = 0, failures = 0, cyc = 0;
  logic [8:0] q[$];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && out_valid && out_ready) begin
    if (q.size() == 0) chk("unexpected_result", {cout, sum}, 9'h1ff ^ {cout, sum});
    else chk("result", {cout, sum}, q.pop_front());
  end

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'b0, c};
  endfunction

  task automatic accept(input logic [7:0] x, input logic [7:0] y, input logic c,
                        input logic [8:0] exp, input bit push);
    int k = 0;
    in_valid = 1'b1; a = x; b = y; cin = c;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("accept_ready", in_ready, 1);
    if (push) q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_zero"}, {out_valid, busy, fa_a, fa_b, fa_cin, cout, sum}, 0);
    chk({n, "_in_ready"}, in_ready, 1);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t vt[6];

  initial begin
    int n, prev;
    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vt[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vt[4] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vt[5] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    #1 chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (vt[i]) begin
      accept(vt[i].a, vt[i].b, vt[i].ci, {vt[i].co, vt[i].s}, 1);
      wait_valid(n);
      chk("latency", n, 8);
      chk("busy_done", busy, 1);
      @(posedge clk); #1;
      chk("idle_back", {in_ready, out_valid, busy}, 3'b100);
      chk("fa_idle_zero", {fa_a, fa_b, fa_cin}, 0);
    end
    // operands change while running must not leak into the result
    accept(8'h12, 8'h34, 1'b0, 9'h046, 1);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      chk("run_in_ready", in_ready, 0);
      @(posedge clk); #1; n++;
    end
    chk("midop_latency", n, 8);
    chk("done_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    // consumer stall holds the result
    out_ready = 1'b0;
    accept(8'hC3, 8'h4D, 1'b1, 9'h111, 1);
    wait_valid(n);
    chk("stall_latency", n, 8);
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_result", {cout, sum}, 9'h111);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {in_ready, out_valid}, 2'b10);
    // abort after the third RUN edge
    accept(8'hAA, 8'h55, 1'b1, 9'h0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    @(posedge clk); #1;
    chk_reset_outputs("abort_hold");
    rst_n = 1'b1;
    chk("post_reset_ready", in_ready, 1);
    accept(8'h03, 8'h04, 1'b0, 9'h007, 1);
    wait_valid(n);
    chk("post_reset_latency", n, 8);
    @(posedge clk); #1;
    // back-to-back with both handshakes tied high
    in_valid = 1'b1; out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(negedge clk);
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      chk("b2b_ready", in_ready, 1);
      q.push_back(model(a, b, cin));
      if (i > 0) chk("b2b_gap", cyc - prev, 10);
      prev = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
